// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-access controller: register map, command
// layout and frame state encoding.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_CHIP_ID   = 7'd0;
    localparam logic [6:0] ADDR_SW_LO     = 7'd1;
    localparam logic [6:0] ADDR_SW_HI     = 7'd2;
    localparam logic [6:0] ADDR_LED_LO    = 7'd3;
    localparam logic [6:0] ADDR_LED_HI    = 7'd4;
    localparam logic [6:0] ADDR_SCRATCH   = 7'd5;
    localparam logic [6:0] ADDR_FRAME_CNT = 7'd6;

    localparam int unsigned CMD_RD_BIT = 7;

    localparam logic [7:0] DEFAULT_CHIP_ID = 8'h07;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for asynchronous inputs; DEPTH flops per bit,
// all cleared by the asynchronous active-high reset.
module sync_ff #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Two-byte-frame register access controller behind an SPI slave shifter:
// decodes command/data bytes, serves reads to the shifter and drives the LEDs.
import spi_reg_pkg::*;

module spi_reg_ctrl #(
    parameter logic [7:0]  CHIP_ID        = DEFAULT_CHIP_ID,
    parameter int unsigned SW_SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ss_active,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_load,
    input  logic [15:0] i_sw,
    output logic [15:0] o_leds
);

    logic [15:0] w_sw_sync;
    logic [7:0]  w_rd_data;

    state_e      r_state;
    logic [7:0]  r_cmd;
    logic [15:0] r_leds;
    logic [7:0]  r_scratch;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_load;

    sync_ff #(
        .WIDTH (16),
        .DEPTH (SW_SYNC_STAGES)
    ) u_sw_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_sw),
        .o_q   (w_sw_sync)
    );

    // Decoded straight from the incoming command byte so the read value is
    // snapshotted into r_tx_data on the same edge that latches the command.
    always_comb begin
        w_rd_data = 8'h00;
        case (i_rx_data[6:0])
            ADDR_CHIP_ID:   w_rd_data = CHIP_ID;
            ADDR_SW_LO:     w_rd_data = w_sw_sync[7:0];
            ADDR_SW_HI:     w_rd_data = w_sw_sync[15:8];
            ADDR_LED_LO:    w_rd_data = r_leds[7:0];
            ADDR_LED_HI:    w_rd_data = r_leds[15:8];
            ADDR_SCRATCH:   w_rd_data = r_scratch;
            ADDR_FRAME_CNT: w_rd_data = r_frame_cnt;
            default:        w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= CMD;
            r_cmd       <= 8'h00;
            r_leds      <= 16'h0000;
            r_scratch   <= 8'h00;
            r_frame_cnt <= 8'h00;
            r_tx_data   <= 8'h00;
            r_tx_load   <= 1'b0;
        end else begin
            r_tx_load <= 1'b0;
            // Deselect aborts any partial frame; a byte arriving alongside is dropped.
            if (!i_ss_active) begin
                r_state <= CMD;
                r_cmd   <= 8'h00;
            end else if (i_rx_valid) begin
                r_tx_load <= 1'b1;
                if (r_state == CMD) begin
                    r_cmd     <= i_rx_data;
                    r_state   <= DATA;
                    r_tx_data <= i_rx_data[CMD_RD_BIT] ? w_rd_data : 8'h00;
                end else begin
                    if (!r_cmd[CMD_RD_BIT]) begin
                        case (r_cmd[6:0])
                            ADDR_LED_LO:  r_leds[7:0]  <= i_rx_data;
                            ADDR_LED_HI:  r_leds[15:8] <= i_rx_data;
                            ADDR_SCRATCH: r_scratch    <= i_rx_data;
                            default:      ;
                        endcase
                    end
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_cmd       <= 8'h00;
                    r_state     <= CMD;
                    r_tx_data   <= 8'h00;
                end
            end
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_load = r_tx_load;
    assign o_leds    = r_leds;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized scoreboard bench for spi_reg_ctrl: a frame-level model predicts each
// transmitted byte and the LED register; a monitor compares on every tx_load.
module tb_spi_reg_ctrl;

    logic        clk;
    logic        rst;
    logic        ss_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [15:0] sw;
    logic [15:0] leds;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  sb[$];
    logic [15:0] m_leds;
    logic [7:0]  m_scratch;
    int          m_frames;
    logic [15:0] m_sw;
    bit          m_in_data;
    logic [7:0]  m_cmd;
    bit          prev_load;

    spi_reg_ctrl #(
        .CHIP_ID        (8'h07),
        .SW_SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ss_active (ss_active),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_tx_data   (tx_data),
        .o_tx_load   (tx_load),
        .i_sw        (sw),
        .o_leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] addr);
        case (addr)
            7'd0:    return 8'h07;
            7'd1:    return m_sw[7:0];
            7'd2:    return m_sw[15:8];
            7'd3:    return m_leds[7:0];
            7'd4:    return m_leds[15:8];
            7'd5:    return m_scratch;
            7'd6:    return m_frames[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: every tx_load must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_load) begin
                check("tx_load_not_back_to_back", {31'd0, prev_load}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_tx_load", 32'd1, 32'd0);
                end else begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
                end
            end
            prev_load = tx_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        if (ss_active) begin
            if (!m_in_data) begin
                m_cmd     = b;
                m_in_data = 1'b1;
                sb.push_back(b[7] ? model_read(b[6:0]) : 8'h00);
            end else begin
                if (!m_cmd[7]) begin
                    if (m_cmd[6:0] == 7'd3) m_leds[7:0] = b;
                    if (m_cmd[6:0] == 7'd4) m_leds[15:8] = b;
                    if (m_cmd[6:0] == 7'd5) m_scratch = b;
                end
                m_frames++;
                m_in_data = 1'b0;
                sb.push_back(8'h00);
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        check("leds", {16'd0, leds}, {16'd0, m_leds});
        tick(3);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] d);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic set_sw(input logic [15:0] v);
        sw   = v;
        m_sw = v;
        tick(3);
    endtask

    task automatic abort_after_cmd(input logic [7:0] c);
        send_byte(c);
        ss_active = 1'b0;
        m_in_data = 1'b0;
        tick(2);
        ss_active = 1'b1;
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_tx_load", {31'd0, tx_load}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_leds", {16'd0, leds}, 32'd0);
        m_leds    = 16'h0000;
        m_scratch = 8'h00;
        m_frames  = 0;
        m_in_data = 1'b0;
        sb.delete();
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    initial begin
        rst       = 1'b1;
        ss_active = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        sw        = 16'h0000;
        m_sw      = 16'h0000;
        m_cmd     = 8'h00;
        prev_load = 1'b0;
        do_reset();
        ss_active = 1'b1;
        tick(2);

        // Chip ID twice, then frame counter
        frame(8'h80, 8'h00);
        frame(8'h80, 8'h00);
        frame(8'h86, 8'h00);

        // Switches and read snapshot
        set_sw(16'h00FF);
        frame(8'h81, 8'h81);
        frame(8'h82, 8'h82);
        send_byte(8'h81);
        sw   = 16'hA5C3;
        m_sw = 16'hA5C3;
        send_byte(8'h00);
        frame(8'h81, 8'h00);
        frame(8'h82, 8'h00);

        // LEDs
        frame(8'h03, 8'hFF);
        frame(8'h04, 8'hAA);
        frame(8'h83, 8'h5A);
        frame(8'h84, 8'h11);
        frame(8'h03, 8'h00);
        frame(8'h04, 8'h00);

        // Protection / unmapped / scratch
        frame(8'h00, 8'h55);
        frame(8'h80, 8'h00);
        frame(8'h7F, 8'h12);
        frame(8'hFF, 8'h00);
        frame(8'h05, 8'h3C);
        frame(8'h85, 8'h00);

        // Abort mid-frame, then same-cycle rx_valid with deselect
        frame(8'h03, 8'h66);
        abort_after_cmd(8'h03);
        frame(8'h81, 8'h00);
        frame(8'h86, 8'h00);
        @(posedge clk);
        #1;
        rx_data   = 8'h04;
        rx_valid  = 1'b1;
        ss_active = 1'b0;
        tick(1);
        rx_valid  = 1'b0;
        ss_active = 1'b1;
        tick(3);
        frame(8'h83, 8'h00);
        frame(8'h86, 8'h00);

        // Reset after a command byte
        frame(8'h04, 8'h9C);
        send_byte(8'h04);
        do_reset();
        ss_active = 1'b1;
        m_sw      = sw;
        tick(2);
        frame(8'h84, 8'h00);
        frame(8'h86, 8'h00);
        frame(8'h81, 8'h00);

        // Wrap: 256 complete frames since reset's 3 above
        for (int i = 0; i < 253; i++) begin
            frame(8'h05, 8'(i));
        end
        frame(8'h86, 8'h00);
        frame(8'h85, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int unsigned r;
            int unsigned a;
            logic [6:0]  addr;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 9);
            addr = (a > 7) ? 7'($urandom_range(7, 127)) : 7'(a);
            if (r == 0) begin
                set_sw(16'($urandom));
            end else if (r == 1) begin
                abort_after_cmd({1'($urandom), addr});
            end else begin
                frame({1'($urandom), addr}, 8'($urandom));
            end
        end
        frame(8'h86, 8'h00);

        tick(4);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Byte-level register-access controller that sits directly downstream of the SPI slave shifter. It consumes received bytes, decodes two-byte frames (command byte, then data byte) and performs register reads and writes. Read results go back to the shifter for transmission during the frame's second byte. The register map holds chip ID, switches, LEDs, a scratch register and a frame counter, and the block drives the board LEDs.

Parameters:
CHIP_ID, 8'h07, value returned on reads of address 0
SW_SYNC_STAGES, 2, synchronizer depth for the switch inputs (min 2)

Ports:
clk  input  1  system clock, 50-100 MHz
rst  input  1  asynchronous, active-high reset
ss_active  input  1  high while SPI slave select is asserted (already synchronized by the shifter)
rx_valid  input  1  one-cycle pulse: a complete byte is on rx_data
rx_data  input  8  received byte, valid when rx_valid=1
tx_data  output  8  byte the shifter transmits next; sampled by the shifter when tx_load=1
tx_load  output  1  one-cycle pulse: tx_data is valid for the next byte
sw  input  16  raw board switches, asynchronous
leds  output  16  LED register contents

Behaviour:
- Frame format: byte0 = command, byte1 = data.
  - Command bit7 = 1 means read, 0 means write; bits[6:0] = address.
  - Every frame is exactly 2 bytes, including reads; the byte1 value received during a read is discarded.
- Register map:
  - 0: CHIP_ID (RO).
  - 1: sw_sync[7:0] (RO).
  - 2: sw_sync[15:8] (RO).
  - 3: leds[7:0] (RW).
  - 4: leds[15:8] (RW).
  - 5: scratch (RW).
  - 6: frame_cnt (RO), counts completed frames, 8-bit, wraps 0xFF -> 0x00.
  - All other addresses read 8'h00; writes to them and to RO addresses are ignored.
- FSM states: CMD, DATA.
  - CMD + rx_valid: latch cmd, go to DATA. If read, next cycle drive tx_data = reg[addr] and pulse tx_load. If write, next cycle drive tx_data = 8'h00 and pulse tx_load.
  - DATA + rx_valid: if the latched cmd is a write, update the target register on the next clock edge. Increment frame_cnt, go to CMD. Next cycle drive tx_data = 8'h00 and pulse tx_load.
- Latency:
  - tx_data/tx_load: exactly 1 clk after rx_valid. The shifter needs them valid well before the first SCK edge of the next byte; SPI half-period >= 20 clk.
  - Register write effect: 1 clk after the data-byte rx_valid.
- Read snapshot: read data is captured at command decode (the cycle after rx_valid). Later changes to the register during byte1 do not alter the transmitted byte.
- ss_active low:
  - Forces state to CMD at the next clock and discards any latched command, with no write and no frame_cnt increment.
  - rx_valid is ignored while ss_active = 0.
- ss_active high -> low mid-frame (after the command byte): the frame is aborted under the same rules.
- rx_valid while ss_active drops in the same cycle: the abort wins and the byte is ignored.
- Switch path: each sw bit passes through an SW_SYNC_STAGES flop synchronizer. Reads return the synchronized value.
- Reset (asynchronous, any time, including mid-frame):
  - State = CMD; leds = 16'h0000; scratch = 8'h00; frame_cnt = 8'h00.
  - tx_data = 8'h00; tx_load = 0; synchronizer flops = 0.
- tx_load is never high for two consecutive cycles.

Decomposition:
- Package spi_reg_pkg:
  - Address constants ADDR_CHIP_ID..ADDR_FRAME_CNT (7-bit).
  - CMD_RD_BIT = 7.
  - FSM state enum {CMD, DATA}.
  - Default CHIP_ID constant.
- Sub-module sync_ff: parameterized width/depth flop synchronizer with async active-high reset, instantiated for sw.
- Register file and decode stay in spi_reg_ctrl.

Test Plan:
- Chip ID: reset, ss_active=1, bytes 80,00 twice -> tx_data=07 loaded 1 clk after the first byte of each frame; frame_cnt=02.
- Switches: sw=00FF, wait 3 clk; frames 81,81 then 82,82 -> read bytes FF then 00. Change sw to A5C3 after the command byte but before byte1 -> transmitted byte is unchanged (snapshot).
- LEDs:
  - Frames 03,FF -> leds=00FF 1 clk after byte1.
  - Frames 04,AA -> leds=AAFF.
  - Frames 83,xx and 84,xx -> reads FF, AA.
  - Writes of 00 to both bytes -> leds=0000.
- Protection/unmapped:
  - Frame 00,55 -> read of addr 0 still 07.
  - Frame 7F,12 -> ignored; frame FF,00 reads 00.
  - Frame 05,3C then 85,00 -> reads 3C.
- Abort: send 03, drop ss_active before byte1, raise it, send 81,00 -> leds unchanged; frame decodes as a switch read; frame_cnt not incremented for the aborted frame.
- Reset and wrap:
  - Assert rst after command byte 04 -> all outputs return to reset values immediately, state=CMD.
  - 256 complete frames -> frame_cnt wraps to 00.
